// File: rtl/wb_pkg.sv
// Write buffer shared types: entry layout, drain FSM states, default depth.
`include "mips_core.svh"

package wb_pkg;
    localparam int WB_DEPTH_DEFAULT = 4;
    localparam int WB_ADDR_WIDTH    = `ADDR_WIDTH;
    localparam int WB_DATA_WIDTH    = 32;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wb_state_t;
endpackage

// File: rtl/mips_core.svh
// Core-wide address width shared by the MEM-stage blocks.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH
`define ADDR_WIDTH 32
`endif

// File: rtl/wb_match_unit.sv
// Address comparator array with youngest-first select; purely combinational,
// no latency, no backpressure.
module wb_match_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t                i_entries [DEPTH],
    input  logic [DEPTH-1:0]         i_valid_mask,
    input  logic [PTR_W-1:0]         i_tail,
    input  logic [WB_ADDR_WIDTH-1:0] i_addr,
    output logic                     o_hit,
    output logic [WB_DATA_WIDTH-1:0] o_data
);

    // Walk oldest to youngest so the slot just behind the tail overrides last.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_tail - PTR_W'(k);
            if (i_valid_mask[w_idx] && (i_entries[w_idx].addr == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/write_buffer_controller.sv
// Store buffer + d-cache drain sequencer; forwarding is 0-cycle (WB_FORWARD_EN), drains take >= 2 cycles/entry.
// Backpressure: o_stall on full store, on a miss load while draining, or on any matching load without WB_FORWARD_EN.
module write_buffer_controller
    import wb_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH_DEFAULT,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic                     i_is_store,
    input  logic                     i_is_load,
    input  logic [WB_ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic                     o_stall,
    output logic                     o_take_write_buffer,
    output logic                     o_fwd_valid,
    output logic [DATA_WIDTH-1:0]    o_fwd_data,
    input  logic                     i_dc_busy,
    output logic                     o_dc_req,
    output logic [WB_ADDR_WIDTH-1:0] o_dc_addr,
    output logic [DATA_WIDTH-1:0]    o_dc_data,
    input  logic                     i_dc_done,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    wb_state_t        r_state;

    logic                     w_load;
    logic                     w_store;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_draining;
    logic                     w_hit;
    logic                     w_miss_load;
    logic                     w_start_drain;
    logic [DEPTH-1:0]         w_valid_mask;
    logic [WB_DATA_WIDTH-1:0] w_hit_data;

    assign w_load        = i_valid & i_is_load;
    assign w_store       = i_valid & i_is_store;
    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign w_push        = w_store & ~w_full;
    assign w_draining    = (r_state == DRAIN);
    assign w_pop         = w_draining & i_dc_done;
    assign w_miss_load   = w_load & ~w_hit;
    assign w_start_drain = (r_state == IDLE) & (r_count != '0) & ~i_dc_busy & ~w_miss_load;

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] w_off;
        w_valid_mask = '0;
        w_off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off           = PTR_W'(i) - r_head;
            w_valid_mask[i] = ({1'b0, w_off} < r_count);
        end
    end

    wb_match_unit #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .i_entries    (r_mem),
        .i_valid_mask (w_valid_mask),
        .i_tail       (r_tail),
        .i_addr       (i_addr),
        .o_hit        (w_hit),
        .o_data       (w_hit_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= IDLE;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            case (r_state)
                IDLE:    if (w_start_drain) r_state <= DRAIN;
                DRAIN:   if (i_dc_done)     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= '{addr: i_addr, data: i_data};
    end

    assign o_dc_req  = w_draining;
    assign o_dc_addr = w_draining ? r_mem[r_head].addr : '0;
    assign o_dc_data = w_draining ? r_mem[r_head].data : '0;
    assign o_empty   = (r_count == '0);

`ifdef WB_FORWARD_EN
    assign o_take_write_buffer = w_load & w_hit;
    assign o_fwd_valid         = w_load & w_hit;
    assign o_fwd_data          = (w_load & w_hit) ? w_hit_data : '0;
    assign o_stall             = (w_store & w_full) | (w_miss_load & w_draining);
`else
    logic w_unused_fwd;
    assign w_unused_fwd        = ^w_hit_data;
    assign o_take_write_buffer = 1'b0;
    assign o_fwd_valid         = 1'b0;
    assign o_fwd_data          = '0;
    // Without forwarding a matching load must wait for its store to drain.
    assign o_stall             = (w_store & w_full) | (w_load & w_hit) | (w_miss_load & w_draining);
`endif

endmodule

// File: tb/tb_write_buffer_controller.sv
// Bench for write_buffer_controller: queue-level model checked every cycle plus directed literal checks.
module tb_write_buffer_controller;
    import wb_pkg::*;

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0, i_is_store = 1'b0, i_is_load = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_data = '0;
    logic          i_dc_busy = 1'b0, i_dc_done = 1'b0;
    logic          o_stall, o_take_write_buffer, o_fwd_valid, o_dc_req, o_empty;
    logic [DW-1:0] o_fwd_data, o_dc_data;
    logic [AW-1:0] o_dc_addr;

    always #5 clk = ~clk;

    write_buffer_controller #(.DEPTH(D), .DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_valid             (i_valid),
        .i_is_store          (i_is_store),
        .i_is_load           (i_is_load),
        .i_addr              (i_addr),
        .i_data              (i_data),
        .o_stall             (o_stall),
        .o_take_write_buffer (o_take_write_buffer),
        .o_fwd_valid         (o_fwd_valid),
        .o_fwd_data          (o_fwd_data),
        .i_dc_busy           (i_dc_busy),
        .o_dc_req            (o_dc_req),
        .o_dc_addr           (o_dc_addr),
        .o_dc_data           (o_dc_data),
        .i_dc_done           (i_dc_done),
        .o_empty             (o_empty)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ment_t;

    ment_t q[$];
    bit    m_drain = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic void mlookup(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] hd);
        hit = 1'b0;
        hd  = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == a) begin
                hit = 1'b1;
                hd  = q[i].d;
                break;
            end
        end
    endfunction

    // Model state update on each edge (reset clears immediately).
    initial forever begin
        bit ld, st, hit, push, pop, nd;
        logic [DW-1:0] hd;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_drain = 1'b0;
        end else begin
            ld = i_valid && i_is_load;
            st = i_valid && i_is_store;
            mlookup(i_addr, hit, hd);
            push = st && (q.size() < D);
            pop  = m_drain && i_dc_done;
            if (m_drain) nd = !i_dc_done;
            else         nd = (q.size() > 0) && !i_dc_busy && !(ld && !hit);
            if (pop)  void'(q.pop_front());
            if (push) q.push_back('{a: i_addr, d: i_data});
            m_drain = nd;
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        bit ld, st, hit, full;
        logic [DW-1:0] hd;
        bit e_take, e_stall;
        logic [DW-1:0] e_fd;
        @(negedge clk);
        ld   = i_valid && i_is_load;
        st   = i_valid && i_is_store;
        full = (q.size() == D);
        mlookup(i_addr, hit, hd);
`ifdef WB_FORWARD_EN
        e_take  = ld && hit;
        e_fd    = e_take ? hd : '0;
        e_stall = (st && full) || (ld && !hit && m_drain);
`else
        e_take  = 1'b0;
        e_fd    = '0;
        e_stall = (st && full) || (ld && hit) || (ld && !hit && m_drain);
`endif
        chk("stall",     o_stall,             e_stall);
        chk("take",      o_take_write_buffer, e_take);
        chk("fwd_valid", o_fwd_valid,         e_take);
        chk("fwd_data",  o_fwd_data,          e_fd);
        chk("dc_req",    o_dc_req,            m_drain);
        chk("dc_addr",   o_dc_addr,           m_drain ? q[0].a : '0);
        chk("dc_data",   o_dc_data,           m_drain ? q[0].d : '0);
        chk("empty",     o_empty,             q.size() == 0);
    end

    task automatic cyc(input bit v, input bit st, input bit ld, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit busy, input bit done);
        @(posedge clk);
        #1;
        i_valid    = v;
        i_is_store = st;
        i_is_load  = ld;
        i_addr     = a;
        i_data     = d;
        i_dc_busy  = busy;
        i_dc_done  = done;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input bit ld, input logic [AW-1:0] a);
        int w;
        w = 0;
        while (!o_dc_req && w < 8) begin
            cyc(ld, 1'b0, ld, a, '0, 1'b0, 1'b0);
            w++;
        end
        chk("drain_req_seen", o_dc_req, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] exp_d [4];

    initial begin
        exp_a[0] = 'h100; exp_d[0] = 32'hDEADBEEF;
        exp_a[1] = 'h40;  exp_d[1] = 32'd1;
        exp_a[2] = 'h40;  exp_d[2] = 32'd2;
        exp_a[3] = 'h44;  exp_d[3] = 32'd3;

        repeat (3) @(negedge clk);
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_req",   o_dc_req, 1'b0);
        chk("rst_stall", o_stall, 1'b0);
        chk("rst_fwd",   o_fwd_data, '0);
        #2 rst_n = 1'b1;

        // store then load the same word while the cache is busy
        cyc(1, 1, 0, 'h100, 32'hDEADBEEF, 1, 0);
        cyc(1, 0, 1, 'h100, '0, 1, 0);
`ifdef WB_FORWARD_EN
        chk("fwd_take", o_take_write_buffer, 1'b1);
        chk("fwd_data_beef", o_fwd_data, 32'hDEADBEEF);
        chk("fwd_nostall", o_stall, 1'b0);
`else
        chk("nofwd_stall", o_stall, 1'b1);
        chk("nofwd_take", o_take_write_buffer, 1'b0);
`endif

        // youngest duplicate wins, then fill to capacity
        cyc(1, 1, 0, 'h40, 32'd1, 1, 0);
        cyc(1, 1, 0, 'h40, 32'd2, 1, 0);
        cyc(1, 0, 1, 'h40, '0, 1, 0);
`ifdef WB_FORWARD_EN
        chk("youngest_data", o_fwd_data, 32'd2);
`else
        chk("youngest_stall", o_stall, 1'b1);
`endif
        cyc(1, 1, 0, 'h44, 32'd3, 1, 0);
        chk("fourth_store_ok", o_stall, 1'b0);
        cyc(1, 1, 0, 'h48, 32'd5, 1, 0);
        chk("full_stall", o_stall, 1'b1);
        cyc(0, 0, 0, '0, '0, 1, 0);
        chk("full_not_empty", o_empty, 1'b0);

        // drain in FIFO order, done arriving in the first DRAIN cycle
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, '0, '0, 0, 0);
            wait_req(1'b0, '0);
            chk("drain_addr", o_dc_addr, exp_a[k]);
            chk("drain_data", o_dc_data, exp_d[k]);
            cyc(0, 0, 0, '0, '0, 0, 1);
        end
        cyc(0, 0, 0, '0, '0, 0, 0);
        chk("drained_empty", o_empty, 1'b1);

        // a missing load blocks the drain start, then stalls while draining
        cyc(1, 1, 0, 'h200, 32'd7, 1, 0);
        cyc(1, 0, 1, 'h300, '0, 0, 0);
        chk("arb_req_held0", o_dc_req, 1'b0);
        chk("arb_idle_nostall", o_stall, 1'b0);
        cyc(1, 0, 1, 'h300, '0, 0, 0);
        chk("arb_req_held1", o_dc_req, 1'b0);
        cyc(0, 0, 0, '0, '0, 0, 0);
        cyc(1, 0, 1, 'h300, '0, 0, 0);
        chk("arb_drain_req", o_dc_req, 1'b1);
        chk("arb_drain_stall0", o_stall, 1'b1);
        cyc(1, 0, 1, 'h300, '0, 0, 0);
        chk("arb_drain_stall1", o_stall, 1'b1);
        cyc(1, 0, 1, 'h300, '0, 0, 1);
        chk("arb_done_stall", o_stall, 1'b1);
        cyc(1, 0, 1, 'h300, '0, 0, 0);
        chk("arb_after_stall", o_stall, 1'b0);
        chk("arb_after_empty", o_empty, 1'b1);

        // asynchronous reset while a drain request is up
        cyc(1, 1, 0, 'h500, 32'h55, 1, 0);
        cyc(0, 0, 0, '0, '0, 0, 0);
        cyc(0, 0, 0, '0, '0, 0, 0);
        chk("pre_rst_req", o_dc_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", o_dc_req, 1'b0);
        chk("mid_rst_empty", o_empty, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // matching load held until its entry drains
        cyc(1, 1, 0, 'h80, 32'd9, 1, 0);
        cyc(1, 0, 1, 'h80, '0, 0, 0);
`ifdef WB_FORWARD_EN
        chk("m80_take", o_take_write_buffer, 1'b1);
        chk("m80_nostall", o_stall, 1'b0);
`else
        chk("m80_stall", o_stall, 1'b1);
        chk("m80_take0", o_take_write_buffer, 1'b0);
`endif
        wait_req(1'b1, 'h80);
        chk("m80_drain_addr", o_dc_addr, 'h80);
        cyc(1, 0, 1, 'h80, '0, 0, 1);
        cyc(1, 0, 1, 'h80, '0, 0, 0);
        chk("m80_released", o_stall, 1'b0);
        chk("m80_take_after", o_take_write_buffer, 1'b0);
        chk("m80_empty", o_empty, 1'b1);

        cyc(0, 0, 0, '0, '0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
